// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART cores: receive FSM state encoding, the
// number of data bits per frame and the idle level of the serial line.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Receive FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous first-word-fall-through FIFO.
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_push, i_push_data: write request and word
//   o_full             : no free entry (a push is still taken if a pop
//                        happens in the same cycle)
//   i_pop              : read request, ignored while empty
//   o_pop_data         : word at the head, valid whenever o_empty is low
//   o_empty            : no stored words
// Pointers carry one extra bit so that full and empty differ only in the MSB.
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty
);

  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LOG2:0]    r_wr_ptr;
  logic [LOG2:0]    r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[LOG2] != r_rd_ptr[LOG2]) &&
                   (r_wr_ptr[LOG2-1:0] == r_rd_ptr[LOG2-1:0]);

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a write when it is being read.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (LOG2 + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (LOG2 + 1)'(1);
    end
  end

  // Storage is cleared on reset so no stale word can appear at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[LOG2-1:0]] <= i_push_data;
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr[LOG2-1:0]];
  assign o_empty    = w_empty;
  assign o_full     = w_full;

endmodule : uart_rx_fifo

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a small receive FIFO and a valid/ack output stream.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   rx        : serial input, asynchronous to clk, idle high
//   div       : baud divider, bit period = div+2 clk cycles (hold stable
//               while a frame is in progress)
//   data      : byte at the FIFO head, LSB received first
//   valid     : data holds an unread byte
//   ack       : pop the head byte (ignored while valid is low)
//   overflow  : one-cycle pulse when a good byte was dropped (FIFO full)
//   frame_err : one-cycle pulse when the stop bit was sampled low
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic [DIV_WIDTH-1:0]      div,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ack,
  output logic                      overflow,
  output logic                      frame_err
);

  localparam int CNT_W     = DIV_WIDTH + 1;
  localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);

  // --------------------------------------------------------------------------
  // Input synchroniser, preset to the idle level so a line held low during
  // reset is not taken as a start bit.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= UART_IDLE_LEVEL;
      r_rx_sync <= UART_IDLE_LEVEL;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rs = r_rx_sync;

  // --------------------------------------------------------------------------
  // Baud counter. One extra bit lets the counter step from 0 to -1; the MSB
  // then marks the tick, L+2 cycles after a load of L. Once at -1 it holds,
  // so an idle receiver never wraps.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_baud_cnt;
  logic             w_tick;
  logic             w_load_full;
  logic             w_load_half;

  assign w_tick = r_baud_cnt[CNT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '1;
    end else if (w_load_full) begin
      r_baud_cnt <= {1'b0, div};
    end else if (w_load_half) begin
      r_baud_cnt <= {1'b0, div >> 1};
    end else if (!w_tick) begin
      r_baud_cnt <= r_baud_cnt - CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  rx_state_e r_state;
  rx_state_e w_state_next;

  logic [BIT_CNT_W-1:0]      r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      w_last_bit;
  logic                      w_shift_en;
  logic                      w_clr_bits;
  logic                      w_push;
  logic                      w_frame_err;

  assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(UART_DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_full  = 1'b0;
    w_load_half  = 1'b0;
    w_shift_en   = 1'b0;
    w_clr_bits   = 1'b0;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_rs != UART_IDLE_LEVEL) begin
          w_load_half  = 1'b1;
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        if (w_tick) begin
          if (w_rs == UART_IDLE_LEVEL) begin
            // Line back high at mid start bit: treat as a glitch.
            w_state_next = ST_IDLE;
          end else begin
            w_load_full  = 1'b1;
            w_clr_bits   = 1'b1;
            w_state_next = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (w_last_bit) w_state_next = ST_STOP;
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          if (w_rs == UART_IDLE_LEVEL) begin
            w_push       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // Hold off until the line returns high so a long low level is
        // reported once rather than as a stream of bad frames.
        if (w_rs == UART_IDLE_LEVEL) w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Data bits arrive LSB first, so each sample enters at the MSB and the
  // register shifts right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_clr_bits) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
      if (w_shift_en) r_shift <= {w_rs, r_shift[UART_DATA_BITS-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO and status pulses
  // --------------------------------------------------------------------------
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [UART_DATA_BITS-1:0] w_fifo_data;
  logic                      w_pop;
  logic                      r_overflow;
  logic                      r_frame_err;

  assign w_pop = ack && !w_fifo_empty;

  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .o_full      (w_fifo_full),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_empty     (w_fifo_empty)
  );

  // A byte is only lost when the FIFO is full and nothing is read in the
  // same cycle; a simultaneous pop makes room for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overflow  <= w_push && w_fifo_full && !w_pop;
      r_frame_err <= w_frame_err;
    end
  end

  assign data      = w_fifo_data;
  assign valid     = !w_fifo_empty;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx core.
- Lets the RP2040 send bytes into the fabric, e.g. commands or payloads that loop back through the existing UART/SPI paths.
- Samples an 8N1 serial line at a programmable baud rate that uses the same divider convention as uart_tx: bit period = div+2 clk cycles.
- Buffers received bytes in a small FIFO and presents them on a valid/ack stream interface.

Parameters:
- DIV_WIDTH, 8, width of the div input and the internal baud counter.
- FIFO_LOG2, 2, log2 of the receive FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock (30 MHz in current top).
- rst_n  input  1  reset; asynchronous assert, active-low.
- rx  input  1  serial input from RP2040; asynchronous to clk; idle high.
- div  input  DIV_WIDTH  baud divider; bit period = div+2 cycles; must be held stable while a frame is in progress.
- data  output  8  byte at the FIFO head; LSB is the first bit received.
- valid  output  1  data holds an unread byte.
- ack  input  1  consumer pop; honoured only in a cycle where valid=1.
- overflow  output  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; FIFO empty.
  - Output values: valid=0, overflow=0, frame_err=0, data=8'h00.
  - Synchroniser flops preset to 1, so a low rx during reset is not seen as a start bit.
  - Reset mid-frame discards the partial byte and all FIFO contents.
- rx synchronisation: 2-flop synchroniser. All decisions use the synchronised value rs.
- Baud counter:
  - Loaded with value L, it counts down through -1. A tick fires when it reaches -1, i.e. L+2 cycles after the load.
  - Full bit: L=div. Half bit: L=div>>1.
- FSM:
  - IDLE: rs=0 → load half-bit, go to START.
  - START: on tick, if rs=1 (glitch) → IDLE with no error. Else load full bit, clear bit counter, go to DATA.
  - DATA: on each tick, shift rs into the shift register MSB, shifting right, and reload full bit. After the 8th sample → STOP.
  - STOP: on tick:
    - rs=1: push byte to FIFO (or drop it and pulse overflow if full), then → IDLE.
    - rs=0: pulse frame_err, discard byte, go to BREAK.
  - BREAK: wait for rs=1, then → IDLE. This prevents a held-low line from retriggering frames.
- Latency: valid rises in the cycle after the stop-bit tick when the FIFO was empty. data is valid in the same cycle (first-word-fall-through).
- FIFO:
  - Depth 2^FIFO_LOG2.
  - Pointers are FIFO_LOG2+1 bits wide, so full/empty are distinguished by the MSB.
  - A push and pop in the same cycle are both performed, including the full-and-ack case: the push is then accepted and no overflow occurs.
  - ack with valid=0 is ignored.
- Minimum div is 1. At div=0 correct operation is not required, but the FSM must not lock up.
- Back-to-back frames: a start edge is accepted in the first cycle back in IDLE after the stop tick.

Decomposition:
- Shared package (uart_pkg):
  - FSM state encoding: IDLE, START, DATA, STOP, BREAK.
  - Constants: UART_DATA_BITS=8, idle line level=1.
- One sub-module, uart_rx_fifo: a synchronous FIFO parameterised by width and log2 depth, with push/full and pop/empty.
- The FIFO is reused later on the SPI fwrite path.

Test Plan:
- Single byte: div=28, rst_n released, rx sends 0xA5 at 30 cycles/bit → valid rises 1 cycle after the stop-bit tick, data=0xA5, ack → valid=0.
- Back-to-back: 0x00, 0xFF, 0x55, 0x3C with no idle gap → four bytes read out in order; no error pulses.
- Overflow: FIFO_LOG2=2, send 5 bytes 0x01..0x05 with ack held 0 → one overflow pulse on the 5th byte; reads return 0x01..0x04.
- Framing error and break: send 0x81 with the stop bit driven 0, then rx held low for 20 bit times, then high → exactly one frame_err pulse; no FIFO write; no further frames until rx has gone high and a new start bit arrives, after which 0x42 is received correctly.
- Glitch rejection: 10-cycle low pulse on rx (less than half a bit) → FSM returns to IDLE; no valid, no error.
- Async reset mid-frame: assert rst_n=0 during data bit 4 with 2 bytes already queued → valid=0 immediately; after release, a fresh 0x99 is received correctly with no stale data.
